// File: rtl/mem_pkg.sv
// Shared definitions for the data RAM responder: lane-select codes, FSM states
// and the write-path lane helpers.
package mem_pkg;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_B0      = 4'b0001;
    localparam logic [3:0] SEL_B1      = 4'b0010;
    localparam logic [3:0] SEL_B2      = 4'b0100;
    localparam logic [3:0] SEL_B3      = 4'b1000;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic sel_legal(input logic [3:0] sel);
        logic ok;
        ok = 1'b0;
        case (sel)
            SEL_WORD, SEL_HALF_LO, SEL_HALF_HI,
            SEL_B0, SEL_B1, SEL_B2, SEL_B3: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Replicate right-aligned store data across lanes so every enabled lane
    // picks up the correct byte without a per-lane shifter.
    function automatic logic [31:0] lane_wdata(input logic [3:0] sel,
                                               input logic [31:0] data);
        logic [31:0] w;
        w = data;
        case (sel)
            SEL_HALF_LO, SEL_HALF_HI:       w = {data[15:0], data[15:0]};
            SEL_B0, SEL_B1, SEL_B2, SEL_B3: w = {4{data[7:0]}};
            default:                        w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lane_extract_ext.sv
// Load-path lane extraction: pulls the selected byte/half out of a word,
// right-aligns it and sign- or zero-extends to 32 bits.
module lane_extract_ext
    import mem_pkg::*;
(
    input  logic [3:0]  sel,
    input  logic        extend,
    input  logic [31:0] word,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = '0;
        case (sel)
            SEL_WORD:    data_out = word;
            SEL_HALF_LO: data_out = {{16{extend & word[15]}}, word[15:0]};
            SEL_HALF_HI: data_out = {{16{extend & word[31]}}, word[31:16]};
            SEL_B0:      data_out = {{24{extend & word[7]}},  word[7:0]};
            SEL_B1:      data_out = {{24{extend & word[15]}}, word[15:8]};
            SEL_B2:      data_out = {{24{extend & word[23]}}, word[23:16]};
            SEL_B3:      data_out = {{24{extend & word[31]}}, word[31:24]};
            default:     data_out = '0;
        endcase
    end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data RAM with byte-lane writes, combinational extended reads,
// a post-reset clear sweep gating ready, and a registered debug read port.
//
// state    | meaning
// ST_CLEAR | sweeping zeros through the array, CPU access blocked, ready=0
// ST_READY | array valid, CPU reads/writes honoured, ready=1
module data_ram_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS  = 12,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-3:0] ram_addr,
    input  logic [31:0]          ram_data_in,
    input  logic [3:0]           ram_sel,
    input  logic                 ram_rw,
    input  logic                 ram_extend_type,
    output logic [31:0]          ram_data_out,
    input  logic                 clr_req,
    output logic                 ready,
    input  logic [ADDR_BITS-3:0] dbg_addr,
    output logic [31:0]          dbg_data
);

    localparam int AW    = ADDR_BITS - 2;
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic          in_clear;
    logic          cpu_we;
    logic [31:0]   wdata;
    logic [31:0]   rd_word;
    logic [31:0]   ext_data;

    assign in_clear = (state == ST_CLEAR);
    assign cpu_we   = (state == ST_READY) && ram_rw && sel_legal(ram_sel);
    assign wdata    = lane_wdata(ram_sel, ram_data_in);

    // Clear and CPU writes are mutually exclusive by state, so one write port suffices.
    always_ff @(posedge clk) begin
        if (in_clear) begin
            mem[clr_ptr] <= '0;
        end else if (cpu_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_sel[i]) mem[ram_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLR_ON_RST ? ST_CLEAR : ST_READY;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_req) begin
                        clr_ptr <= '0;
                    end else if (clr_ptr == '1) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                        ready   <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_ptr <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dbg_data <= '0;
        else      dbg_data <= mem[dbg_addr];
    end

    assign rd_word = mem[ram_addr];

    lane_extract_ext u_lane_extract_ext (
        .sel      (ram_sel),
        .extend   (ram_extend_type),
        .word     (rd_word),
        .data_out (ext_data)
    );

    assign ram_data_out = (state == ST_READY && !ram_rw) ? ext_data : '0;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  ram_addr = '0;
    logic [31:0] ram_data_in = '0;
    logic [3:0]  ram_sel = '0;
    logic        ram_rw = 1'b0;
    logic        ram_extend_type = 1'b0;
    logic [31:0] ram_data_out;
    logic        clr_req = 1'b0;
    logic        ready;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    localparam int K_DOUT  = 0;
    localparam int K_READY = 1;
    localparam int K_DBG   = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] act;
    int          n_chk  = 0;
    int          n_fail = 0;

    data_ram_responder #(.ADDR_BITS(12), .CLR_ON_RST(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .ram_addr        (ram_addr),
        .ram_data_in     (ram_data_in),
        .ram_sel         (ram_sel),
        .ram_rw          (ram_rw),
        .ram_extend_type (ram_extend_type),
        .ram_data_out    (ram_data_out),
        .clr_req         (clr_req),
        .ready           (ready),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            case (cur.kind)
                K_DOUT:  act = ram_data_out;
                K_READY: act = {31'b0, ready};
                default: act = dbg_data;
            endcase
            n_chk++;
            if (act !== cur.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.val);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic rw, input logic ext);
        ram_addr        = a;
        ram_data_in     = d;
        ram_sel         = s;
        ram_rw          = rw;
        ram_extend_type = ext;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(a, d, s, 1'b1, 1'b0);
        step();
        ram_rw = 1'b0;
    endtask

    task automatic read_chk(input logic [9:0] a, input logic [3:0] s, input logic ext,
                            input logic [31:0] v, input string name);
        drive(a, 32'h0, s, 1'b0, ext);
        expect_val(K_DOUT, v, name);
        step();
    endtask

    task automatic dbg_chk(input logic [9:0] a, input logic [31:0] v, input string name);
        dbg_addr = a;
        step();
        expect_val(K_DBG, v, name);
        step();
    endtask

    // Counts edges after the sweep starts (sweep already running after edge 0).
    task automatic sweep_wait(input string tag);
        for (int cyc = 1; cyc <= 1024; cyc++) begin
            step();
            if (cyc == 1023) expect_val(K_READY, 32'h0, {tag, "_ready_low_1023"});
            if (cyc == 1024) expect_val(K_READY, 32'h1, {tag, "_ready_high_1024"});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles
        dbg_addr = 10'd17;
        step(3);
        n_chk++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_rst_ready: got %b expected 0", ready);
        end
        expect_val(K_READY, 32'h0, "rst_ready");
        expect_val(K_DBG,   32'h0, "rst_dbg");
        step();
        rst = 1'b1;

        // Sweep after reset, with a dropped write and a blocked read inside it
        for (int cyc = 1; cyc <= 1024; cyc++) begin
            step();
            if (cyc == 100) drive(10'd7, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0);
            if (cyc == 101) begin
                drive(10'd7, 32'h0, 4'b1111, 1'b0, 1'b0);
                expect_val(K_DOUT, 32'h0, "clear_read_zero");
            end
            if (cyc == 1023) expect_val(K_READY, 32'h0, "init_ready_low_1023");
            if (cyc == 1024) expect_val(K_READY, 32'h1, "init_ready_high_1024");
        end
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_init_ready: got %b expected 1", ready);
        end
        read_chk(10'd7, 4'b1111, 1'b0, 32'h0, "clear_write_dropped");
        dbg_chk(10'd7,   32'h0, "dbg_after_clear_7");
        dbg_chk(10'd1023, 32'h0, "dbg_after_clear_1023");

        // Word write and extended sub-word reads
        cpu_write(10'd5, 32'h8081_F2F3, 4'b1111);
        drive(10'd5, 32'h0, 4'b1111, 1'b0, 1'b1);
        #1;
        n_chk++;
        if (ram_data_out !== 32'h8081F2F3) begin
            n_fail++;
            $display("FAIL direct_rd_word: got %h expected 8081f2f3", ram_data_out);
        end
        read_chk(10'd5, 4'b1111, 1'b1, 32'h8081F2F3, "rd_word");
        read_chk(10'd5, 4'b0001, 1'b1, 32'hFFFFFFF3, "rd_b0_sext");
        read_chk(10'd5, 4'b0001, 1'b0, 32'h000000F3, "rd_b0_zext");
        read_chk(10'd5, 4'b1100, 1'b1, 32'hFFFF8081, "rd_hhi_sext");
        read_chk(10'd5, 4'b0100, 1'b0, 32'h00000081, "rd_b2_zext");
        read_chk(10'd5, 4'b0011, 1'b0, 32'h0000F2F3, "rd_hlo_zext");
        read_chk(10'd5, 4'b1000, 1'b1, 32'hFFFFFF80, "rd_b3_sext");
        read_chk(10'd5, 4'b0111, 1'b1, 32'h0,        "rd_illegal_sel");
        read_chk(10'd5, 4'b0000, 1'b0, 32'h0,        "rd_zero_sel");

        // Byte write, illegal-sel write, half write
        cpu_write(10'd5, 32'h0000_00AA, 4'b0010);
        read_chk(10'd5, 4'b1111, 1'b0, 32'h8081AAF3, "byte_write_b1");
        cpu_write(10'd5, 32'h1234_5678, 4'b0110);
        read_chk(10'd5, 4'b1111, 1'b0, 32'h8081AAF3, "illegal_write_ignored");
        cpu_write(10'd6, 32'h0000_1234, 4'b1100);
        read_chk(10'd6, 4'b1111, 1'b0, 32'h12340000, "half_write_hi");
        read_chk(10'd6, 4'b1000, 1'b1, 32'h00000012, "rd_b3_pos_sext");
        cpu_write(10'd6, 32'hFFFF_9ABC, 4'b0011);
        read_chk(10'd6, 4'b0011, 1'b1, 32'hFFFF9ABC, "half_write_lo_sext");

        // Same-cycle write: output 0 while writing, debug shows pre-edge word
        dbg_addr = 10'd5;
        drive(10'd5, 32'h1122_3344, 4'b1111, 1'b1, 1'b0);
        expect_val(K_DOUT, 32'h0, "rw1_out_zero");
        step();
        ram_rw = 1'b0;
        expect_val(K_DBG, 32'h8081AAF3, "dbg_old_contents");
        step();
        expect_val(K_DBG, 32'h11223344, "dbg_new_contents");
        read_chk(10'd5, 4'b1111, 1'b0, 32'h11223344, "word_overwrite");

        // clr_req in READY
        clr_req = 1'b1;
        drive(10'd5, 32'h0, 4'b1111, 1'b0, 1'b0);
        step();
        clr_req = 1'b0;
        expect_val(K_READY, 32'h0, "clr_req_ready_fall");
        expect_val(K_DOUT,  32'h0, "clr_req_read_blocked");
        step(1023);
        expect_val(K_READY, 32'h0, "clr_ready_low_1023");
        step();
        expect_val(K_READY, 32'h1, "clr_ready_high_1024");
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_clr_ready: got %b expected 1", ready);
        end
        read_chk(10'd5, 4'b1111, 1'b0, 32'h0, "clr_addr5_zero");
        read_chk(10'd6, 4'b1111, 1'b0, 32'h0, "clr_addr6_zero");

        // Reset mid-sweep at clr_ptr=300
        cpu_write(10'd1000, 32'h5A5A_5A5A, 4'b1111);
        read_chk(10'd1000, 4'b1111, 1'b0, 32'h5A5A5A5A, "pre_reset_write");
        dbg_addr = 10'd1000;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step(300);
        rst = 1'b0;
        #1;
        expect_val(K_READY, 32'h0, "midsweep_rst_ready");
        expect_val(K_DBG,   32'h0, "midsweep_rst_dbg");
        step(2);
        rst = 1'b1;
        sweep_wait("rst_sweep");
        read_chk(10'd1000, 4'b1111, 1'b0, 32'h0, "rst_sweep_addr1000_zero");
        dbg_chk(10'd1000, 32'h0, "rst_sweep_dbg1000_zero");

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
